// File: rtl/ara_pkg.sv
// Shared types for the accelerator issue buffer: the buffered request payload
// and the drain/flush sequencing states.
package ara_pkg;

   localparam int unsigned AccelXlen = 64;

   typedef struct packed {
      logic [31:0]          insn;
      logic [AccelXlen-1:0] rs1;
      logic [AccelXlen-1:0] rs2;
   } accel_issue_payload_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } accel_issue_state_e;

endpackage

// File: rtl/accel_issue_fifo.sv
// Storage and pointers for the accelerator issue buffer. Callers gate push/pop
// with full/empty; the head entry is presented combinationally on rdata_o.
module accel_issue_fifo
   import ara_pkg::*;
#(
   parameter int unsigned Depth  = 4,
   parameter type         data_t = accel_issue_payload_t
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  push_i,
   input  data_t wdata_i,
   input  logic  pop_i,
   output data_t rdata_o,
   output logic  full_o,
   output logic  empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0] count_q;
   data_t           mem_q [Depth];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wptr_q <= wptr_q + 1'b1;
         if (pop_i)  rptr_q <= rptr_q + 1'b1;
         unique case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the data array has no reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/accel_issue_buffer.sv
// Decoupling FIFO between an accelerator instruction source and Ara, with
// outstanding tracking, drain/flush sequencing and optional stall counters
// (enabled by defining ACCEL_ISSUE_BUF_PERF_EN).
module accel_issue_buffer
   import ara_pkg::*;
#(
   parameter  int unsigned Depth          = 4,
   parameter  int unsigned XLEN           = AccelXlen,
   parameter  int unsigned MaxOutstanding = 8,
   localparam int unsigned OutW           = $clog2(MaxOutstanding + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [31:0]     up_insn_i,
   input  logic [XLEN-1:0] up_rs1_i,
   input  logic [XLEN-1:0] up_rs2_i,
   input  logic            up_valid_i,
   output logic            up_ready_o,
   output logic [31:0]     dn_insn_o,
   output logic [XLEN-1:0] dn_rs1_o,
   output logic [XLEN-1:0] dn_rs2_o,
   output logic            dn_valid_o,
   input  logic            dn_ready_i,
   input  logic            resp_valid_i,
   input  logic [XLEN-1:0] resp_result_i,
   input  logic            resp_error_i,
   output logic            resp_ready_o,
   input  logic            flush_i,
   output logic            flush_done_o,
   output logic [OutW-1:0] outstanding_o,
   output logic            idle_o,
   output logic            error_o
`ifdef ACCEL_ISSUE_BUF_PERF_EN
   ,
   output logic [63:0]     perf_up_stall_o,
   output logic [63:0]     perf_dn_stall_o
`endif
);

   accel_issue_state_e   state_q, state_d;
   logic [OutW-1:0]      out_q, out_d;
   logic                 error_q, error_d;
   logic                 push, pop, full, empty, resp_match;
   accel_issue_payload_t wdata, rdata;

   accel_issue_fifo #(
      .Depth  (Depth),
      .data_t (accel_issue_payload_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .wdata_i (wdata),
      .pop_i   (pop),
      .rdata_o (rdata),
      .full_o  (full),
      .empty_o (empty)
   );

   assign wdata      = '{insn: up_insn_i, rs1: up_rs1_i, rs2: up_rs2_i};
   assign up_ready_o = !full && (state_q == RUN);
   assign push       = up_valid_i && up_ready_o;
   assign dn_valid_o = !empty && (out_q < OutW'(MaxOutstanding));
   assign pop        = dn_valid_o && dn_ready_i;
   // A response with nothing outstanding is a protocol error and must not underflow.
   assign resp_match = resp_valid_i && (out_q != '0);

   // Head data is masked while empty so the unreset array never leaks out.
   assign dn_insn_o = empty ? '0 : rdata.insn;
   assign dn_rs1_o  = empty ? '0 : rdata.rs1;
   assign dn_rs2_o  = empty ? '0 : rdata.rs2;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      error_d = error_q;
      if (resp_valid_i && (resp_error_i || (out_q == '0))) error_d = 1'b1;
      unique case ({pop, resp_match})
         2'b10:   out_d = out_q + 1'b1;
         2'b01:   out_d = out_q - 1'b1;
         default: out_d = out_q;
      endcase
      unique case (state_q)
         RUN:     if (flush_i) state_d = DRAIN;
         DRAIN:   if (empty && (out_q == '0)) state_d = DONE;
         DONE:    state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         out_q   <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         error_q <= error_d;
      end
   end

   assign resp_ready_o  = 1'b1;
   assign flush_done_o  = (state_q == DONE);
   assign outstanding_o = out_q;
   assign idle_o        = empty && (out_q == '0) && (state_q == RUN);
   assign error_o       = error_q;

`ifdef ACCEL_ISSUE_BUF_PERF_EN
   logic [63:0] perf_up_q, perf_dn_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_up_q <= '0;
         perf_dn_q <= '0;
      end else begin
         if (up_valid_i && !up_ready_o) perf_up_q <= perf_up_q + 64'd1;
         if (dn_valid_o && !dn_ready_i) perf_dn_q <= perf_dn_q + 64'd1;
      end
   end

   assign perf_up_stall_o = perf_up_q;
   assign perf_dn_stall_o = perf_dn_q;
`endif

endmodule

// File: tb/tb_accel_issue_buffer.sv
// Directed bench for accel_issue_buffer (Depth=4, MaxOutstanding=8). Inputs are
// driven 1 ns after the rising edge and outputs are checked in the same window.
module tb_accel_issue_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] up_insn;
   logic [63:0] up_rs1, up_rs2;
   logic        up_valid, up_ready;
   logic [31:0] dn_insn;
   logic [63:0] dn_rs1, dn_rs2;
   logic        dn_valid, dn_ready;
   logic        resp_valid, resp_error, resp_ready;
   logic [63:0] resp_result;
   logic        flush, flush_done, idle, error;
   logic [3:0]  outstanding;
`ifdef ACCEL_ISSUE_BUF_PERF_EN
   logic [63:0] perf_up, perf_dn;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   accel_issue_buffer dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .up_insn_i     (up_insn),
      .up_rs1_i      (up_rs1),
      .up_rs2_i      (up_rs2),
      .up_valid_i    (up_valid),
      .up_ready_o    (up_ready),
      .dn_insn_o     (dn_insn),
      .dn_rs1_o      (dn_rs1),
      .dn_rs2_o      (dn_rs2),
      .dn_valid_o    (dn_valid),
      .dn_ready_i    (dn_ready),
      .resp_valid_i  (resp_valid),
      .resp_result_i (resp_result),
      .resp_error_i  (resp_error),
      .resp_ready_o  (resp_ready),
      .flush_i       (flush),
      .flush_done_o  (flush_done),
      .outstanding_o (outstanding),
      .idle_o        (idle),
      .error_o       (error)
`ifdef ACCEL_ISSUE_BUF_PERF_EN
      ,
      .perf_up_stall_o (perf_up),
      .perf_dn_stall_o (perf_dn)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; up_valid = 1'b0; up_insn = '0; up_rs1 = '0; up_rs2 = '0;
      dn_ready = 1'b0; resp_valid = 1'b0; resp_error = 1'b0; resp_result = '0;
      flush = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic push_n(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         up_valid = 1'b1; up_insn = base + i; up_rs1 = 64'(base + i) + 64'h1000;
         tick();
      end
      up_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (up_ready !== 1'b1)    begin bad++; $display("FAIL reset_up_ready got=%0b exp=1", up_ready); end
      total++; if (dn_valid !== 1'b0)    begin bad++; $display("FAIL reset_dn_valid got=%0b exp=0", dn_valid); end
      total++; if ({dn_insn, dn_rs1, dn_rs2} !== '0) begin bad++; $display("FAIL reset_dn_data got=%h exp=0", {dn_insn, dn_rs1, dn_rs2}); end
      total++; if (flush_done !== 1'b0)  begin bad++; $display("FAIL reset_flush_done got=%0b exp=0", flush_done); end
      total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
      total++; if (idle !== 1'b1)        begin bad++; $display("FAIL reset_idle got=%0b exp=1", idle); end
      total++; if (error !== 1'b0)       begin bad++; $display("FAIL reset_error got=%0b exp=0", error); end
      total++; if (resp_ready !== 1'b1)  begin bad++; $display("FAIL reset_resp_ready got=%0b exp=1", resp_ready); end
   endtask

   task automatic test_single();
      do_reset();
      dn_ready = 1'b1;
      up_valid = 1'b1; up_insn = 32'h0200_7057; up_rs1 = 64'd5; up_rs2 = 64'd9;
      total++; if (dn_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%0b exp=0", dn_valid); end
      tick();
      up_valid = 1'b0;
      total++; if (dn_valid !== 1'b1) begin bad++; $display("FAIL single_dn_valid got=%0b exp=1", dn_valid); end
      total++; if (dn_insn !== 32'h0200_7057 || dn_rs1 !== 64'd5 || dn_rs2 !== 64'd9)
         begin bad++; $display("FAIL single_data got=%h/%0d/%0d exp=02007057/5/9", dn_insn, dn_rs1, dn_rs2); end
      total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL single_out_pre got=%0d exp=0", outstanding); end
      tick();
      total++; if (outstanding !== 4'd1 || idle !== 1'b0) begin bad++; $display("FAIL single_out_issued got=%0d/%0b exp=1/0", outstanding, idle); end
      resp_valid = 1'b1; resp_result = 64'd42;
      tick();
      resp_valid = 1'b0;
      total++; if (outstanding !== 4'd0 || idle !== 1'b1) begin bad++; $display("FAIL single_out_resp got=%0d/%0b exp=0/1", outstanding, idle); end
      total++; if (error !== 1'b0) begin bad++; $display("FAIL single_error got=%0b exp=0", error); end
   endtask

   task automatic test_full();
      do_reset();
      push_n(4, 32'd1);
      total++; if (up_ready !== 1'b0) begin bad++; $display("FAIL full_up_ready got=%0b exp=0", up_ready); end
      up_valid = 1'b1; up_insn = 32'd5;
      tick();
      total++; if (up_ready !== 1'b0 || dn_insn !== 32'd1) begin bad++; $display("FAIL full_held got=%0b/%0d exp=0/1", up_ready, dn_insn); end
      up_valid = 1'b0;
      dn_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         total++; if (dn_valid !== 1'b1 || dn_insn !== 32'(i) || dn_rs1 !== 64'(i) + 64'h1000)
            begin bad++; $display("FAIL full_order_%0d got=%0b/%0d exp=1/%0d", i, dn_valid, dn_insn, i); end
         tick();
      end
      total++; if (dn_valid !== 1'b0 || outstanding !== 4'd4) begin bad++; $display("FAIL full_drained got=%0b/%0d exp=0/4", dn_valid, outstanding); end
   endtask

   task automatic test_max_outstanding();
      do_reset();
      dn_ready = 1'b1;
      push_n(10, 32'h100);
      total++; if (outstanding !== 4'd8 || dn_valid !== 1'b0) begin bad++; $display("FAIL maxout_cap got=%0d/%0b exp=8/0", outstanding, dn_valid); end
      total++; if (dn_insn !== 32'h108 || idle !== 1'b0) begin bad++; $display("FAIL maxout_head got=%h/%0b exp=108/0", dn_insn, idle); end
      resp_valid = 1'b1;
      tick();
      resp_valid = 1'b0;
      total++; if (outstanding !== 4'd7 || dn_valid !== 1'b1) begin bad++; $display("FAIL maxout_resp got=%0d/%0b exp=7/1", outstanding, dn_valid); end
      tick();
      total++; if (outstanding !== 4'd8 || dn_valid !== 1'b0 || dn_insn !== 32'h109)
         begin bad++; $display("FAIL maxout_reissue got=%0d/%0b/%h exp=8/0/109", outstanding, dn_valid, dn_insn); end
   endtask

   task automatic test_flush();
      int pulses = 0;
      do_reset();
      push_n(4, 32'h21);
      dn_ready = 1'b1;
      tick(); tick();
      dn_ready = 1'b0;
      push_n(1, 32'h25);
      total++; if (outstanding !== 4'd2 || up_ready !== 1'b1) begin bad++; $display("FAIL flush_setup got=%0d/%0b exp=2/1", outstanding, up_ready); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (up_ready !== 1'b0) begin bad++; $display("FAIL flush_up_ready got=%0b exp=0", up_ready); end
      up_valid = 1'b1; up_insn = 32'hEE;
      tick();
      up_valid = 1'b0;
      dn_ready = 1'b1;
      tick(); tick(); tick();
      total++; if (outstanding !== 4'd5 || dn_valid !== 1'b0) begin bad++; $display("FAIL flush_issued got=%0d/%0b exp=5/0", outstanding, dn_valid); end
      resp_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (flush_done === 1'b1) pulses++;
      end
      resp_valid = 1'b0;
      total++; if (outstanding !== 4'd0 || up_ready !== 1'b0) begin bad++; $display("FAIL flush_drained got=%0d/%0b exp=0/0", outstanding, up_ready); end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (flush_done === 1'b1) pulses++;
         if (i == 0) begin
            total++; if (flush_done !== 1'b1) begin bad++; $display("FAIL flush_done_pulse got=%0b exp=1", flush_done); end
         end
         if (i == 1) begin
            total++; if (up_ready !== 1'b1 || idle !== 1'b1) begin bad++; $display("FAIL flush_resume got=%0b/%0b exp=1/1", up_ready, idle); end
         end
      end
      total++; if (pulses !== 1) begin bad++; $display("FAIL flush_pulse_count got=%0d exp=1", pulses); end
   endtask

   task automatic test_flush_idle();
      do_reset();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (flush_done !== 1'b0 || idle !== 1'b0) begin bad++; $display("FAIL flush_idle_drain got=%0b/%0b exp=0/0", flush_done, idle); end
      tick();
      total++; if (flush_done !== 1'b1) begin bad++; $display("FAIL flush_idle_done got=%0b exp=1", flush_done); end
      tick();
      total++; if (flush_done !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL flush_idle_back got=%0b/%0b exp=0/1", flush_done, idle); end
   endtask

   task automatic test_error();
      do_reset();
      dn_ready = 1'b1;
      push_n(3, 32'h40);
      tick();
      total++; if (outstanding !== 4'd3) begin bad++; $display("FAIL err_setup got=%0d exp=3", outstanding); end
      resp_valid = 1'b1;
      tick();
      total++; if (error !== 1'b0 || outstanding !== 4'd2) begin bad++; $display("FAIL err_first got=%0b/%0d exp=0/2", error, outstanding); end
      resp_error = 1'b1;
      tick();
      resp_error = 1'b0; resp_valid = 1'b0;
      total++; if (error !== 1'b1 || outstanding !== 4'd1) begin bad++; $display("FAIL err_second got=%0b/%0d exp=1/1", error, outstanding); end
      push_n(1, 32'h50);
      resp_valid = 1'b1;
      total++; if (dn_valid !== 1'b1) begin bad++; $display("FAIL err_pop_ready got=%0b exp=1", dn_valid); end
      tick();
      total++; if (outstanding !== 4'd1 || error !== 1'b1) begin bad++; $display("FAIL err_pop_resp got=%0d/%0b exp=1/1", outstanding, error); end
      tick();
      resp_valid = 1'b0;
      total++; if (outstanding !== 4'd0 || error !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0d/%0b exp=0/1", outstanding, error); end
      do_reset();
      total++; if (error !== 1'b0) begin bad++; $display("FAIL err_cleared got=%0b exp=0", error); end
      resp_valid = 1'b1;
      tick();
      resp_valid = 1'b0;
      total++; if (error !== 1'b1 || outstanding !== 4'd0) begin bad++; $display("FAIL err_underflow got=%0b/%0d exp=1/0", error, outstanding); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      push_n(4, 32'h60);
      dn_ready = 1'b1;
      tick(); tick(); tick();
      dn_ready = 1'b0;
      push_n(1, 32'h64);
      total++; if (outstanding !== 4'd3 || dn_valid !== 1'b1 || dn_insn !== 32'h63)
         begin bad++; $display("FAIL mid_setup got=%0d/%0b/%h exp=3/1/63", outstanding, dn_valid, dn_insn); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (dn_valid !== 1'b0 || outstanding !== 4'd0 || idle !== 1'b1 || up_ready !== 1'b1)
         begin bad++; $display("FAIL mid_reset got=%0b/%0d/%0b/%0b exp=0/0/1/1", dn_valid, outstanding, idle, up_ready); end
      tick();
      total++; if (dn_valid !== 1'b0 || dn_insn !== 32'h0) begin bad++; $display("FAIL mid_discard got=%0b/%h exp=0/0", dn_valid, dn_insn); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_max_outstanding();
      test_flush();
      test_flush_idle();
      test_error();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
